video_ula: RTL and testbench
============================

// Module: video_ula
// PURPOSE
// - ZX48 ULA video stage: pixel/line counters, sync/blank/INT generation, display-file fetch, pixel shifter, colour out.
// - Clocked by the 7.000 MHz pixel clock from the clock generator; one pixel per clock, 448x312 per frame.
// - Drives video RAM (13-bit address, 1-cycle synchronous read) and feeds the RGBI/sync output stage; INT goes to the Z80.
// PARAMETERS
// - HLEN      448  pixel clocks per line (hc wraps HLEN-1 -> 0)
// - VLEN      312  lines per frame (vc wraps VLEN-1 -> 0)
// - INT_LEN    64  INT low width in pixel clocks (32 T-states)
// PORTS
// - clock    in   1   7.000 MHz pixel clock, only clock in block
// - reset    in   1   asynchronous, active-low reset
// - border   in   3   border colour {G,R,B}, sampled every clock
// - vd       in   8   video RAM read data, valid the cycle after va
// - va       out  13  video RAM address (bitmap or attribute)
// - hsync    out  1   active-low horizontal sync
// - vsync    out  1   active-low vertical sync
// - blank    out  1   high during h or v blanking
// - int_n    out  1   active-low Z80 maskable interrupt
// - rgbi     out  4   {bright,G,R,B}; 0000 while blank
// - hcount   out  9   current hc (debug/contention use)
// - vcount   out  9   current vc
// BEHAVIOUR
// - Reset (async assert, sync release): hc=vc=0, frame counter=0, shifter/latches=0, va=0, hsync=vsync=int_n=1, blank=0, rgbi=0.
// - hc increments every clock; at HLEN-1 wraps to 0 and vc increments; vc wraps VLEN-1 -> 0 and frame counter (5 bit) increments.
// - Display area: hc<256 && vc<192. Right border hc 256..319, left border 416..447, bottom border vc 192..247, top 256..311.
// - hblank hc 320..415; hsync hc 344..375; vblank vc 248..255; vsync vc 248..251; blank = hblank|vblank.
// - int_n low when vc==248 && hc<INT_LEN; exactly INT_LEN clocks per frame.
// - All outputs registered and mutually aligned: values seen in cycle k derive from hc/vc of cycle k-1 (1-clock latency).
// - Fetch counter fc=(hc+8) mod HLEN; fetch line fl = (hc>=440) ? (vc+1) mod VLEN : vc; fetch enabled iff fc<256 && fl<192.
// - Fetch per column: fc[2:0]==0 registers va={fl[7:6],fl[2:0],fl[5:3],fc[7:3]} (bitmap); fc[2:0]==1 registers
//   va={3'b110,fl[7:3],fc[7:3]} (attribute); vd latched as bitmap at end of fc[2:0]==2, attribute at end of fc[2:0]==3.
// - va holds last value when fetch disabled (no RAM side effects; no read strobe).
// - At hc[2:0]==7 shifter/attr register load from latches if next column is display, else load zeros; bit 7 drives pixel at hc[2:0]==0.
// - Pixel colour: ink=attr[2:0], paper=attr[5:3], bright=attr[6]; pixel bit XOR (attr[7] & frame[4]) selects ink(1)/paper(0).
// - Border area: rgbi={1'b0,border}; blank area: rgbi=0000 (blank has priority over border).
// - Flash period 32 frames (16 on/16 off), frame counter wraps 31 -> 0 freely.
// - border changes take effect on the next registered output; no mid-pixel glitches.
// - Reset mid-frame: everything returns to reset values at once; first line after release restarts at hc=vc=0.
// STRUCTURE
// - Shared package/include zx48_video_pkg: HLEN/VLEN, display/border/blank/sync/INT boundary constants, bitmap/attr address functions.
// - One natural sub-module: ula_shifter (8-bit pixel shift register + attribute latch + flash/ink/paper mux).
// - Counters, decode, fetch sequencer stay in top level; no FSM beyond fetch phase = fc[2:0].
// TESTING
// - Reset released, run 448*312 clocks -> hc/vc wrap exactly once each, frame counter 0 -> 1.
// - Sweep one line -> hsync low for exactly 32 clocks starting at output cycle for hc=344; blank high 96 clocks.
// - Frame scan -> int_n low 64 clocks at vc=248,hc=0..63, once per frame; vsync low 4 lines.
// - RAM model with 1-cycle latency, bitmap 0x4000-style addr 0x0000=0xAA, attr 0x1800=0x47 -> first 8 display pixels
//   at vc=0 alternate rgbi 1111/1000; va=0x0000 then 0x1800 issued at hc=440/441 of previous line (vc=311).
// - Attr 0xC7 with pixel 0xFF -> rgbi 1111 frames 0..15, 1000 frames 16..31 (flash swap).
// - border=3'b010 at vc=200 -> rgbi 0010 in border, 0000 in blank; assert reset at vc=100 -> all outputs reset values same cycle.

Source files
------------

// File: rtl/zx48_video_pkg.sv
// ZX48 video timing constants, display-file address mapping and pixel colour mux.
package zx48_video_pkg;
  localparam logic [8:0] HLEN_DEF         = 9'd448;
  localparam logic [8:0] VLEN_DEF         = 9'd312;
  localparam logic [8:0] INT_LEN_DEF      = 9'd64;
  localparam logic [8:0] DISP_W           = 9'd256;
  localparam logic [8:0] DISP_H_DEF       = 9'd192;
  localparam logic [8:0] HBLANK_FIRST     = 9'd320;
  localparam logic [8:0] HBLANK_LAST      = 9'd415;
  localparam logic [8:0] HSYNC_FIRST      = 9'd344;
  localparam logic [8:0] HSYNC_LAST       = 9'd375;
  localparam logic [8:0] VBLANK_FIRST_DEF = 9'd248;
  localparam logic [8:0] VBLANK_LINES     = 9'd8;
  localparam logic [8:0] VSYNC_LINES      = 9'd4;
  localparam logic [8:0] FETCH_LEAD       = 9'd8;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic int_n;
  } sync_t;

  // Bitmap rows are interleaved: third, pixel row within cell, cell row.
  function automatic logic [12:0] bitmap_addr(input logic [7:0] line, input logic [4:0] col);
    return {line[7:6], line[2:0], line[5:3], col};
  endfunction

  function automatic logic [12:0] attr_addr(input logic [7:0] line, input logic [4:0] col);
    return {3'b110, line[7:3], col};
  endfunction

  function automatic logic [3:0] pixel_colour(input logic pix, input logic [7:0] attr,
                                              input logic flash);
    logic ink_sel;
    ink_sel = pix ^ (attr[7] & flash);
    return {attr[6], ink_sel ? attr[2:0] : attr[5:3]};
  endfunction
endpackage

// File: rtl/ula_shifter.sv
// Pixel shift register and attribute latch; presents the colour of the current pixel.
module ula_shifter
  import zx48_video_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] bitmap,
  input  logic [7:0] attr_in,
  input  logic       flash,
  output logic [3:0] colour
);
  logic [7:0] sh, attr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh   <= '0;
      attr <= '0;
    end else if (load) begin
      sh   <= bitmap;
      attr <= attr_in;
    end else begin
      sh <= {sh[6:0], 1'b0};
    end
  end

  assign colour = pixel_colour(sh[7], attr, flash);
endmodule

// File: rtl/video_ula.sv
// ZX48 ULA video stage: beam counters, sync/blank/INT decode, display-file fetch, colour out.
module video_ula
  import zx48_video_pkg::*;
#(
  parameter logic [8:0] HLEN         = HLEN_DEF,
  parameter logic [8:0] VLEN         = VLEN_DEF,
  parameter logic [8:0] INT_LEN      = INT_LEN_DEF,
  parameter logic [8:0] DISP_H       = DISP_H_DEF,
  parameter logic [8:0] VBLANK_FIRST = VBLANK_FIRST_DEF,
  parameter int         FLASH_BIT    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  border,
  input  logic [7:0]  vd,
  output logic [12:0] va,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        int_n,
  output logic [3:0]  rgbi,
  output logic [8:0]  hcount,
  output logic [8:0]  vcount
);
  logic [8:0] hc, vc;
  logic [4:0] frame;
  logic       hc_last, vc_last;

  assign hc_last = (hc == HLEN - 9'd1);
  assign vc_last = (vc == VLEN - 9'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hc    <= '0;
      vc    <= '0;
      frame <= '0;
    end else begin
      hc <= hc_last ? 9'd0 : hc + 9'd1;
      if (hc_last) begin
        vc <= vc_last ? 9'd0 : vc + 9'd1;
        if (vc_last) frame <= frame + 5'd1;
      end
    end
  end

  // Fetch runs one column (8 clocks) ahead of the beam, wrapping into the next line.
  logic [9:0] fsum;
  logic [8:0] fc, fl;
  logic       fetch_en;

  always_comb begin
    fsum = {1'b0, hc} + 10'(FETCH_LEAD);
    if (fsum >= {1'b0, HLEN}) fsum = fsum - {1'b0, HLEN};
    fc = fsum[8:0];
    fl = vc;
    if (hc >= HLEN - FETCH_LEAD) fl = vc_last ? 9'd0 : vc + 9'd1;
    fetch_en = (fc < DISP_W) && (fl < DISP_H);
  end

  logic [7:0] bm_lat, at_lat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      va     <= '0;
      bm_lat <= '0;
      at_lat <= '0;
    end else if (fetch_en) begin
      case (fc[2:0])
        3'd0:    va     <= bitmap_addr(fl[7:0], fc[7:3]);
        3'd1:    va     <= attr_addr(fl[7:0], fc[7:3]);
        3'd2:    bm_lat <= vd;
        3'd3:    at_lat <= vd;
        default: ;
      endcase
    end
  end

  // At the last pixel of a column, fetch_en already describes the column about to start.
  logic [3:0] pix;

  ula_shifter u_shifter (
    .clock  (clock),
    .reset  (reset),
    .load   (hc[2:0] == 3'd7),
    .bitmap (fetch_en ? bm_lat : 8'h00),
    .attr_in(fetch_en ? at_lat : 8'h00),
    .flash  (frame[FLASH_BIT]),
    .colour (pix)
  );

  logic  disp, vblank;
  sync_t nxt;

  always_comb begin
    disp      = (hc < DISP_W) && (vc < DISP_H);
    vblank    = (vc >= VBLANK_FIRST) && (vc < VBLANK_FIRST + VBLANK_LINES);
    nxt.hsync = !((hc >= HSYNC_FIRST) && (hc <= HSYNC_LAST));
    nxt.vsync = !((vc >= VBLANK_FIRST) && (vc < VBLANK_FIRST + VSYNC_LINES));
    nxt.blank = ((hc >= HBLANK_FIRST) && (hc <= HBLANK_LAST)) || vblank;
    nxt.int_n = !((vc == VBLANK_FIRST) && (hc < INT_LEN));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      blank  <= 1'b0;
      int_n  <= 1'b1;
      rgbi   <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      hsync  <= nxt.hsync;
      vsync  <= nxt.vsync;
      blank  <= nxt.blank;
      int_n  <= nxt.int_n;
      rgbi   <= nxt.blank ? 4'h0 : (disp ? pix : {1'b0, border});
      hcount <= hc;
      vcount <= vc;
    end
  end
endmodule

// File: tb/tb_video_ula.sv
// Bench for video_ula with a shortened frame (26 lines) so several frames fit in a short run.
module tb_video_ula;
  localparam int H_LEN  = 448;
  localparam int V_LEN  = 26;
  localparam int D_H    = 12;
  localparam int VB     = 16;
  localparam int I_LEN  = 64;
  localparam int FB     = 1;
  localparam int FRAME  = H_LEN * V_LEN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  border = 3'b000;
  logic [7:0]  vd;
  logic [12:0] va;
  logic        hsync, vsync, blank, int_n;
  logic [3:0]  rgbi;
  logic [8:0]  hcount, vcount;

  always #5 clock = ~clock;

  video_ula #(
    .HLEN(9'(H_LEN)), .VLEN(9'(V_LEN)), .INT_LEN(9'(I_LEN)),
    .DISP_H(9'(D_H)), .VBLANK_FIRST(9'(VB)), .FLASH_BIT(FB)
  ) dut (
    .clock(clock), .reset(reset), .border(border), .vd(vd), .va(va),
    .hsync(hsync), .vsync(vsync), .blank(blank), .int_n(int_n),
    .rgbi(rgbi), .hcount(hcount), .vcount(vcount)
  );

  logic [7:0] mem [0:8191];
  always @(posedge clock) vd <= mem[va];

  typedef struct packed {
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hsync, vsync, blank, int_n;
    logic [3:0] rgbi;
  } obs_t;

  typedef struct {
    int          h, v;
    logic [2:0]  b;
    logic [3:0]  sync_e;
    logic [3:0]  rgbi_e;
    logic        va_chk;
    logic [12:0] va_e;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0;
  int   k = 0;
  int   force_pos = -1;
  logic [2:0] force_b = 3'b000;
  bit   first_run = 1'b1;
  int   hs0 = 0, bl0 = 0, int_cnt = 0, vs_cnt = 0;

  function automatic obs_t model(input int p, input logic [2:0] b);
    obs_t o;
    int h, v, f, bma, ata;
    logic [7:0] bm, at;
    logic px, sel, fl;
    h = p % H_LEN;
    v = (p / H_LEN) % V_LEN;
    f = (p / FRAME) % 32;
    fl = ((f >> FB) & 1) == 1;
    o.hcount = 9'(h);
    o.vcount = 9'(v);
    o.hsync  = !(h >= 344 && h <= 375);
    o.vsync  = !(v >= VB && v < VB + 4);
    o.blank  = (h >= 320 && h <= 415) || (v >= VB && v < VB + 8);
    o.int_n  = !(v == VB && h < I_LEN);
    if (o.blank) o.rgbi = 4'b0000;
    else if (h < 256 && v < D_H) begin
      // Column 0 of the very first line after reset was never fetched.
      if (p < 8) o.rgbi = 4'b0000;
      else begin
        bma = (v / 64) * 2048 + (v % 8) * 256 + ((v / 8) % 8) * 32 + h / 8;
        ata = 6144 + (v / 8) * 32 + h / 8;
        bm = mem[bma];
        at = mem[ata];
        px = bm[7 - (h % 8)];
        sel = px ^ (at[7] & fl);
        o.rgbi = {at[6], sel ? at[2:0] : at[5:3]};
      end
    end else o.rgbi = {1'b0, b};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s pos=%0d: got %0h want %0h", name, k - 1, act, exp);
    end
  endtask

  function automatic logic [2:0] pick_border(input int pos);
    if (pos == force_pos) return force_b;
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic check_model(input int p, input logic [2:0] b);
    obs_t e, a;
    e = model(p, b);
    a = {hcount, vcount, hsync, vsync, blank, int_n, rgbi};
    chk("model", 32'(a), 32'(e));
    if (first_run && p < FRAME) begin
      if (p < H_LEN && !hsync) hs0++;
      if (p < H_LEN && blank) bl0++;
      if (!int_n) int_cnt++;
      if (!vsync) vs_cnt++;
    end
  endtask

  task automatic step();
    logic [2:0] b_used;
    b_used = border;
    @(posedge clock);
    k++;
    @(negedge clock);
    check_model(k - 1, b_used);
    border = pick_border(k);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    if (k - 1 > target) chk("order", 32'(k - 1), 32'(target));
    while (k - 1 < target && n < 200000) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, 32'({hcount, vcount, hsync, vsync, blank, int_n, rgbi, va}),
        32'({9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 13'd0}));
  endtask

  task automatic add(input int h, input int v, input logic [2:0] b, input logic [3:0] s,
                     input logic [3:0] c, input logic vc_, input logic [12:0] ve);
    vec_t t;
    t.h = h; t.v = v; t.b = b; t.sync_e = s; t.rgbi_e = c; t.va_chk = vc_; t.va_e = ve;
    tbl.push_back(t);
  endtask

  initial begin
    logic [3:0] exp_c;
    // {hsync, vsync, blank, int_n}
    add(  0,  0, 3'b111, 4'b1101, 4'b0000, 1'b0, 13'h0000);
    add(300,  0, 3'b001, 4'b1101, 4'b0001, 1'b1, 13'h181F);
    add(343,  0, 3'b001, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(344,  0, 3'b001, 4'b0111, 4'b0000, 1'b0, 13'h0000);
    add(375,  0, 3'b001, 4'b0111, 4'b0000, 1'b0, 13'h0000);
    add(376,  0, 3'b001, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(319,  5, 3'b101, 4'b1101, 4'b0101, 1'b0, 13'h0000);
    add(320,  5, 3'b101, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(415,  5, 3'b110, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(416,  5, 3'b011, 4'b1101, 4'b0011, 1'b0, 13'h0000);
    add(256,  6, 3'b100, 4'b1101, 4'b0100, 1'b0, 13'h0000);
    add(100, 12, 3'b010, 4'b1101, 4'b0010, 1'b0, 13'h0000);
    add(  0, 16, 3'b010, 4'b1010, 4'b0000, 1'b0, 13'h0000);
    add( 63, 16, 3'b010, 4'b1010, 4'b0000, 1'b0, 13'h0000);
    add( 64, 16, 3'b010, 4'b1011, 4'b0000, 1'b0, 13'h0000);
    add(  0, 19, 3'b010, 4'b1011, 4'b0000, 1'b0, 13'h0000);
    add(  0, 20, 3'b010, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(447, 23, 3'b010, 4'b1111, 4'b0000, 1'b0, 13'h0000);
    add(  0, 24, 3'b110, 4'b1101, 4'b0110, 1'b0, 13'h0000);
    add(440, 25, 3'b001, 4'b1101, 4'b0001, 1'b1, 13'h0000);
    add(441, 25, 3'b001, 4'b1101, 4'b0001, 1'b1, 13'h1800);
    add(447, 25, 3'b001, 4'b1101, 4'b0001, 1'b0, 13'h0000);

    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h0000] = 8'hAA;
    mem[13'h1800] = 8'h47;
    mem[13'h0001] = 8'hFF;
    mem[13'h1801] = 8'hC7;

    repeat (3) @(negedge clock);
    chk_reset_vals("reset_hold");
    border = pick_border(0);
    reset = 1'b1;
    k = 0;
    #1 chk_reset_vals("reset_release");

    for (int i = 0; i < tbl.size(); i++) begin
      force_pos = tbl[i].v * H_LEN + tbl[i].h;
      force_b = tbl[i].b;
      border = pick_border(k);
      run_to(force_pos);
      chk("sync", 32'({hsync, vsync, blank, int_n}), 32'(tbl[i].sync_e));
      chk("rgbi", 32'(rgbi), 32'(tbl[i].rgbi_e));
      chk("beam", 32'({hcount, vcount}), 32'({9'(tbl[i].h), 9'(tbl[i].v)}));
      if (tbl[i].va_chk) chk("va", 32'(va), 32'(tbl[i].va_e));
    end
    force_pos = -1;

    chk("hsync_width", 32'(hs0), 32'd32);
    chk("hblank_width", 32'(bl0), 32'd96);
    chk("int_width", 32'(int_cnt), 32'(I_LEN));
    chk("vsync_width", 32'(vs_cnt), 32'(4 * H_LEN));

    // 0xAA/0x47 alternates bright white/bright black; 0xFF/0xC7 flips with flash.
    for (int f = 1; f <= 2; f++)
      for (int x = 0; x < 16; x++) begin
        run_to(f * FRAME + x);
        if (x < 8) exp_c = (x % 2 == 0) ? 4'b1111 : 4'b1000;
        else exp_c = (f == 2) ? 4'b1000 : 4'b1111;
        chk("first_pixels", 32'(rgbi), 32'(exp_c));
      end

    run_to(3 * FRAME + 5 * H_LEN + 100);
    #2 reset = 1'b0;
    #1 chk_reset_vals("reset_async");
    @(posedge clock);
    @(negedge clock);
    chk_reset_vals("reset_held");
    first_run = 1'b0;
    border = pick_border(0);
    reset = 1'b1;
    k = 0;
    run_to(FRAME + 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
